// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: state encoding, widths and saturating duty step shared by the speed controller
package motor_ctrl_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;
    localparam int DUTY_W = 8;
    localparam int SPEED_W = 16;

    function automatic logic [DUTY_W-1:0] sat_step(
        input logic [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0] step,
        input logic dn,
        input logic [DUTY_W-1:0] lo_v
    );
        logic [DUTY_W:0] up_v;
        up_v = {1'b0, d} + {1'b0, step};
        if (dn)
            return ({1'b0, d} < {1'b0, lo_v} + {1'b0, step}) ? lo_v : d - step;
        return up_v[DUTY_W] ? '1 : up_v[DUTY_W-1:0];
    endfunction
endpackage

// File: rtl/motor_speed_ctrl_pwm_gen.sv
// pwm_gen: prescaled 8-bit PWM counter with duty latched only at wrap and a forced-zero override
module pwm_gen
    import motor_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50
) (
    input  logic              clk0,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty,
    input  logic              force_zero,
    output logic              pwm,
    output logic              wrap
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]     pre;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] active;
    logic              tick;

    assign tick = pre == PW'(PRESCALE - 1);
    assign wrap = tick && cnt == '1;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            pre    <= '0;
            cnt    <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                cnt <= cnt + 1'b1;
            if (force_zero)
                active <= '0;
            else if (wrap)
                active <= duty;
            pwm <= !force_zero && cnt < active;
        end
    end
endmodule

// File: rtl/motor_speed_ctrl.sv
// motor_speed_ctrl: hall-driven duty regulator with start-up, stall watchdog and PWM; MOTOR_SOFTSTART_EN ramps START duty
module motor_speed_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int START_DUTY = 128,
    parameter int MIN_DUTY   = 16,
    parameter int STEP       = 4,
    parameter int DEADBAND   = 20,
    parameter int PRESCALE   = 50,
    parameter int TIMEOUT    = 1000000
) (
    input  logic               clk0,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SPEED_W-1:0] target,
    input  logic [SPEED_W-1:0] speed,
    input  logic               speed_valid,
    output logic               pwm,
    output logic [DUTY_W-1:0]  duty,
    output logic [1:0]         state,
    output logic               stall
);
`ifdef MOTOR_SOFTSTART_EN
    localparam logic SOFT = 1'b1;
`else
    localparam logic SOFT = 1'b0;
`endif

    logic [1:0]        state_n;
    logic [DUTY_W-1:0] duty_n;
    logic [31:0]       wd;
    logic [31:0]       wd_n;
    logic [SPEED_W:0]  lo;
    logic [SPEED_W:0]  hi_raw;
    logic [SPEED_W:0]  hi;
    logic              below;
    logic              above;
    logic              expire;
    logic              wrap;

    // band edges in 17 bits so neither end wraps
    assign lo     = ({1'b0, target} >= 17'(DEADBAND)) ? {1'b0, target} - 17'(DEADBAND) : '0;
    assign hi_raw = {1'b0, target} + 17'(DEADBAND);
    assign hi     = hi_raw[SPEED_W] ? 17'h0FFFF : hi_raw;
    assign below  = {1'b0, speed} < lo;
    assign above  = {1'b0, speed} > hi;
    assign expire = wd == 32'(TIMEOUT - 1) && !speed_valid;

    always_comb begin
        state_n = state;
        duty_n  = duty;
        wd_n    = '0;
        if (!en) begin
            state_n = IDLE;
            duty_n  = '0;
        end else if (state == IDLE) begin
            state_n = START;
            duty_n  = SOFT ? '0 : DUTY_W'(START_DUTY);
        end else if (state == FAULT) begin
            duty_n = '0;
        end else if (expire) begin
            state_n = FAULT;
            duty_n  = '0;
        end else if (speed_valid) begin
            state_n = RUN;
            if (state == RUN && (below || above))
                duty_n = sat_step(duty, DUTY_W'(STEP), above, DUTY_W'(MIN_DUTY));
        end else begin
            wd_n = wd + 32'd1;
            if (SOFT && state == START && wrap && duty < DUTY_W'(START_DUTY))
                duty_n = duty + 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state <= IDLE;
            duty  <= '0;
            wd    <= '0;
            stall <= 1'b0;
        end else begin
            state <= state_n;
            duty  <= duty_n;
            wd    <= wd_n;
            stall <= state_n == FAULT;
        end
    end

    pwm_gen #(.PRESCALE(PRESCALE)) u_pwm (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .duty      (duty),
        .force_zero(state_n == IDLE || state_n == FAULT),
        .pwm       (pwm),
        .wrap      (wrap)
    );
endmodule

// File: tb/tb_motor_speed_ctrl.sv
// tb_motor_speed_ctrl: scoreboard bench with an arithmetic speed-regulation model
module tb_motor_speed_ctrl;
    localparam int SD = 130;
    localparam int MIND = 16;
    localparam int STP = 4;
    localparam int DB = 20;
    localparam int TO = 100;

    logic        clk0 = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] target = 16'd1000;
    logic [15:0] speed = 16'd0;
    logic        speed_valid = 1'b0;
    logic        pwm;
    logic [7:0]  duty;
    logic [1:0]  state;
    logic        stall;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mstate = 0;
    int mduty = 0;
    int tgt_cur = 1000;
    int since = 0;
    bit keep = 1'b1;
    int e;

    motor_speed_ctrl #(
        .START_DUTY(SD), .MIN_DUTY(MIND), .STEP(STP),
        .DEADBAND(DB), .PRESCALE(1), .TIMEOUT(TO)
    ) dut (
        .clk0(clk0), .rst_n(rst_n), .en(en), .target(target), .speed(speed),
        .speed_valid(speed_valid), .pwm(pwm), .duty(duty), .state(state), .stall(stall)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_sample(input int s, input int t);
        int lo, hi;
        if (mstate == 1) begin
            mstate = 2;
        end else if (mstate == 2) begin
            lo = (t - DB < 0) ? 0 : t - DB;
            hi = (t + DB > 65535) ? 65535 : t + DB;
            if (s < lo)
                mduty = (mduty + STP > 255) ? 255 : mduty + STP;
            else if (s > hi)
                mduty = (mduty - STP < MIND) ? MIND : mduty - STP;
        end
    endtask

    task automatic samp(input int s, input int t, input bit ev);
        speed = 16'(s);
        target = 16'(t);
        en = ev;
        tgt_cur = t;
        speed_valid = 1'b1;
        if (!ev) begin
            mstate = 0;
            mduty = 0;
        end else begin
            model_sample(s, t);
        end
        exp_q.push_back((mstate == 3 ? 1024 : 0) + mstate * 256 + mduty);
        since = 0;
        @(negedge clk0);
        speed_valid = 1'b0;
    endtask

    task automatic cyc();
        if (keep && since >= 40) begin
            samp(tgt_cur, tgt_cur, en);
        end else begin
            since++;
            @(negedge clk0);
        end
    endtask

    task automatic reenable();
        en = 1'b1;
        cyc();
        mstate = 1;
        mduty = SD;
        check("start_state", int'(state), 1);
        check("start_duty", int'(duty), SD);
    endtask

    task automatic wait_rise(input string name);
        bit prev;
        int n;
        prev = pwm;
        n = 0;
        cyc();
        while (!(!prev && pwm) && n < 600) begin
            prev = pwm;
            n++;
            cyc();
        end
        if (n >= 600) check(name, 0, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk0);
            if (speed_valid && rst_n) begin
                @(negedge clk0);
                if (exp_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", int'({stall, state, duty}), e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual 1 required 0");
        $fatal(1, "timeout");
    end

    initial begin
        int hi_cnt, run, s, t;
        repeat (3) @(negedge clk0);
        check("rst_state", int'(state), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_pwm", int'(pwm), 0);
        rst_n = 1'b1;
        cyc();
        reenable();
        samp(900, 1000, 1);
        samp(900, 1000, 1);
        samp(1015, 1000, 1);
        samp(1021, 1000, 1);
        repeat (32) samp(0, 1000, 1);
        samp(0, 10, 1);
        samp(31, 10, 1);
        samp(30, 10, 1);
        samp(500, 1000, 0);
        reenable();
        repeat (30) samp(65535, 1000, 1);
        repeat (12) samp(0, 1000, 1);
        check("duty64", int'(duty), 64);
        hi_cnt = 0;
        for (int i = 0; i < 768; i++) begin
            cyc();
            if (i >= 512 && pwm) hi_cnt++;
        end
        check("pwm_high_64", hi_cnt, 64);
        wait_rise("rise_timeout1");
        run = 1;
        samp(65535, 1000, 1);
        while (pwm && run < 400) begin
            run++;
            cyc();
        end
        check("pwm_old_period", run, 64);
        wait_rise("rise_timeout2");
        run = 0;
        while (pwm && run < 400) begin
            run++;
            cyc();
        end
        check("pwm_new_period", run, 60);
        keep = 1'b0;
        samp(1000, 1000, 1);
        repeat (99) cyc();
        check("wd_before", int'(state), 2);
        cyc();
        check("wd_fault", int'(state), 3);
        check("wd_stall", int'(stall), 1);
        check("wd_pwm", int'(pwm), 0);
        check("wd_duty", int'(duty), 0);
        mstate = 3;
        mduty = 0;
        samp(0, 1000, 1);
        repeat (5) cyc();
        check("fault_hold", int'(state), 3);
        en = 1'b0;
        cyc();
        mstate = 0;
        check("fault_exit", int'(state), 0);
        check("fault_exit_stall", int'(stall), 0);
        reenable();
        samp(1000, 1000, 1);
        repeat (99) cyc();
        samp(900, 1000, 1);
        repeat (50) cyc();
        check("expiry_race", int'(state), 2);
        samp(900, 1000, 0);
        keep = 1'b1;
        reenable();
        samp(1000, 1000, 1);
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: t = $urandom_range(0, 40);
                1: t = $urandom_range(65500, 65535);
                default: t = $urandom_range(0, 65535);
            endcase
            s = t + $urandom_range(0, 60) - 30;
            if (s < 0) s = 0;
            if (s > 65535) s = 65535;
            if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 65535);
            if ($urandom_range(0, 24) == 0) begin
                samp(s, t, 0);
                reenable();
            end else begin
                samp(s, t, 1);
            end
            repeat ($urandom_range(0, 15)) cyc();
        end
        repeat (3) cyc();
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/motor_speed_ctrl.md
# motor_speed_ctrl

Closed-loop speed controller that sequences the motor drive around the hall speed measurement. It consumes each new `speed` sample from the hall block and a `target` setpoint, then adjusts an 8-bit PWM duty in fixed steps. It also runs a start-up phase and a stall watchdog. It sits between the hall measurement path and the motor driver pin.

## Interface
Parameters:
- `START_DUTY`, default 128: duty applied in START.
- `MIN_DUTY`, default 16: lower duty clamp in RUN.
- `STEP`, default 4: duty increment or decrement per sample.
- `DEADBAND`, default 20: speed tolerance band around `target`.
- `PRESCALE`, default 50: `clk0` cycles per PWM counter tick.
- `TIMEOUT`, default 1000000: `clk0` cycles without a sample before stall.

Ports:
- `clk0` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: run request, level-sensitive.
- `target` in 16: speed setpoint, in the same units as `speed`.
- `speed` in 16: measured speed from the hall block.
- `speed_valid` in 1: one-cycle pulse when `speed` is updated.
- `pwm` out 1: motor drive output.
- `duty` out 8: current commanded duty.
- `state` out 2: 0 = IDLE, 1 = START, 2 = RUN, 3 = FAULT.
- `stall` out 1: high while in FAULT.

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0, active duty 0.
- IDLE: duty = 0. When `en` = 1, go to START and clear the watchdog.
- START: duty = `START_DUTY`. The first `speed_valid` moves the block to RUN; that sample is not used for regulation. Watchdog expiry moves the block to FAULT.
- RUN, on each `speed_valid`:
  - lo = `target` − `DEADBAND`, saturating at 0.
  - hi = `target` + `DEADBAND`, saturating at 65535. Compute both in 17 bits.
  - If `speed` < lo: duty = min(duty + `STEP`, 255).
  - If `speed` > hi: duty = max(duty − `STEP`, `MIN_DUTY`).
  - Otherwise duty is unchanged.
  - Clear the watchdog.
- FAULT: duty = 0, `stall` = 1. Leave only through `en` = 0, which goes to IDLE.
- `en` = 0 in any state: go to IDLE next cycle with duty = 0. This takes priority over all other transitions.
- Watchdog: counts `clk0` cycles in START and RUN. When it reaches `TIMEOUT` − 1 with no `speed_valid` in that cycle, go to FAULT. A `speed_valid` in the same cycle as expiry wins: the sample is processed and the watchdog clears. Held at 0 in IDLE and FAULT.
- PWM generation:
  - An 8-bit counter advances once every `PRESCALE` `clk0` cycles and wraps 255 → 0.
  - `duty` is copied into the active duty register only at the wrap tick.
  - `pwm` = (counter < active duty), so it is glitch-free. Duty 255 gives 255/256 high; duty 0 gives constant low.
  - Exception: when entering IDLE or FAULT, active duty is forced to 0 immediately.

## Timing
- `duty` is updated on the cycle after `speed_valid`, so latency is 1 cycle.
- `state` and `stall` are registered; they change on the cycle after the triggering condition.
- `pwm` is registered and reflects a new duty from the first counter period after the next wrap. The maximum delay is 256 × `PRESCALE` cycles.
- Extra `speed_valid` pulses in IDLE or FAULT are ignored.
- A `target` change takes effect at the next sample. No filtering is applied.

## Configuration
- `MOTOR_SOFTSTART_EN` defined:
  - START ramps duty from 0 toward `START_DUTY` by +1 at each PWM wrap, saturating at `START_DUTY`.
  - The START → RUN transition requires a `speed_valid` and is allowed at any ramp level.
  - RUN regulation continues from the current ramp value.
- `MOTOR_SOFTSTART_EN` undefined: duty jumps straight to `START_DUTY` on entry to START.

## Structure
- Package `motor_ctrl_pkg` holds:
  - the state encoding constants IDLE, START, RUN, FAULT;
  - `DUTY_W` = 8 and `SPEED_W` = 16;
  - a saturating add/subtract helper function.
- Sub-module `pwm_gen` contains the prescaler, the 8-bit counter, wrap-synchronised duty latching and the forced-zero input.

## Test plan
- Enable and regulate up: reset, `en` = 1, `target` = 1000, `speed_valid` with `speed` = 900 → state 1 then 2. Duty stays 128 for the first sample. The next sample at 900 gives duty 132.
- Deadband hold: in RUN, `speed` = 1015 with `target` = 1000 → duty unchanged. `speed` = 1021 → duty −4.
- Saturation: duty 254 with `speed` = 0 → duty 255. Duty 18 with `speed` = 65535 → duty 16. Also check `target` = 10, where lo = 0 and there is no wrap.
- Stall watchdog: `TIMEOUT` = 100, no `speed_valid` after RUN → FAULT at cycle 100, `stall` = 1, `pwm` = 0. Hold `en` = 1 → remains FAULT. Drop `en` → IDLE.
- Simultaneous events: `speed_valid` exactly at expiry → stays RUN. `en` = 0 together with `speed_valid` → IDLE, duty 0.
- PWM: `PRESCALE` = 1, duty 64 → `pwm` high 64 of 256 cycles. A duty change mid-period takes effect only after the wrap. `MOTOR_SOFTSTART_EN` build: START duty rises 0, 1, 2, … at each wrap.
